// File: rtl/tick_debounce_unit.sv
`default_nettype none
// ============================================================================
// Module   : tick_debounce_unit
// Brief    : Turns Clk190 rising edges into one-cycle ticks and uses them to
//            debounce N_BTN buttons into clean levels plus press/release strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tick_debounce_unit #(
  parameter int N_BTN        = 4,
  parameter int STABLE_TICKS = 4,
  parameter int CNT_W        = 3
) (
  input  logic             mClk,
  input  logic             Reset,
  input  logic             Clk190,
  input  logic [N_BTN-1:0] btn_raw,
  output logic             tick,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_rel
);

  localparam logic [CNT_W-1:0] c_STABLE_CNT = CNT_W'(STABLE_TICKS);
  localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RELEASED   = 2'd0,
    ST_PRESS_PEND = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_REL_PEND   = 2'd3
  } state_t;

  logic             r_s190_m;
  logic             r_s190;
  logic             r_s190_d;
  logic             r_tick;
  logic [N_BTN-1:0] r_btn_m;
  logic [N_BTN-1:0] r_btn_s;
  logic             w_tick;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_rel;

  // Clk190 chain resets high so a divider already high at reset gives no tick.
  always_ff @(posedge mClk) begin
    if (Reset) begin
      r_s190_m <= 1'b1;
      r_s190   <= 1'b1;
      r_s190_d <= 1'b1;
      r_tick   <= 1'b0;
      r_btn_m  <= '0;
      r_btn_s  <= '0;
    end else begin
      r_s190_m <= Clk190;
      r_s190   <= r_s190_m;
      r_s190_d <= r_s190;
      r_tick   <= w_tick;
      r_btn_m  <= btn_raw;
      r_btn_s  <= r_btn_m;
    end
  end

  assign w_tick = r_s190 & ~r_s190_d;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      state_t           r_state;
      logic [CNT_W-1:0] r_cnt;
      logic             r_lvl;
      logic             r_prs;
      logic             r_rls;
      logic             w_s;
      logic [CNT_W-1:0] w_cnt_inc;

      assign w_s       = r_btn_s[gi];
      assign w_cnt_inc = r_cnt + c_ONE;

      always_ff @(posedge mClk) begin
        if (Reset) begin
          r_state <= ST_RELEASED;
          r_cnt   <= '0;
          r_lvl   <= 1'b0;
          r_prs   <= 1'b0;
          r_rls   <= 1'b0;
        end else begin
          r_prs <= 1'b0;
          r_rls <= 1'b0;
          if (w_tick) begin
            case (r_state)
              ST_RELEASED: begin
                if (w_s) begin
                  if (STABLE_TICKS == 1) begin
                    r_state <= ST_PRESSED;
                    r_lvl   <= 1'b1;
                    r_prs   <= 1'b1;
                    r_cnt   <= '0;
                  end else begin
                    r_state <= ST_PRESS_PEND;
                    r_cnt   <= c_ONE;
                  end
                end else begin
                  r_cnt <= '0;
                end
              end
              ST_PRESS_PEND: begin
                if (w_s) begin
                  if (w_cnt_inc == c_STABLE_CNT) begin
                    r_state <= ST_PRESSED;
                    r_lvl   <= 1'b1;
                    r_prs   <= 1'b1;
                    r_cnt   <= '0;
                  end else begin
                    r_cnt <= w_cnt_inc;
                  end
                end else begin
                  // bounce reject: any disagreeing sample restarts qualification
                  r_state <= ST_RELEASED;
                  r_cnt   <= '0;
                end
              end
              ST_PRESSED: begin
                if (!w_s) begin
                  if (STABLE_TICKS == 1) begin
                    r_state <= ST_RELEASED;
                    r_lvl   <= 1'b0;
                    r_rls   <= 1'b1;
                    r_cnt   <= '0;
                  end else begin
                    r_state <= ST_REL_PEND;
                    r_cnt   <= c_ONE;
                  end
                end else begin
                  r_cnt <= '0;
                end
              end
              ST_REL_PEND: begin
                if (!w_s) begin
                  if (w_cnt_inc == c_STABLE_CNT) begin
                    r_state <= ST_RELEASED;
                    r_lvl   <= 1'b0;
                    r_rls   <= 1'b1;
                    r_cnt   <= '0;
                  end else begin
                    r_cnt <= w_cnt_inc;
                  end
                end else begin
                  r_state <= ST_PRESSED;
                  r_cnt   <= '0;
                end
              end
              default: begin
                r_state <= ST_RELEASED;
                r_lvl   <= 1'b0;
                r_cnt   <= '0;
              end
            endcase
          end
        end
      end

      assign w_level[gi] = r_lvl;
      assign w_press[gi] = r_prs;
      assign w_rel[gi]   = r_rls;
    end
  endgenerate

  assign tick      = r_tick;
  assign btn_level = w_level;
  assign btn_press = w_press;
  assign btn_rel   = w_rel;

endmodule
`default_nettype wire

// File: tb/tb_tick_debounce_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_debounce_unit
// Brief    : Directed bench for tick_debounce_unit, Clk190 at 8 mClk period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_debounce_unit;

  logic       mClk;
  logic       Reset;
  logic       Clk190;
  logic [3:0] btn_raw;
  logic       tick;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_rel;

  int n_chk;
  int n_pass;
  bit run190;
  int cnt190;

  tick_debounce_unit #(
    .N_BTN       (4),
    .STABLE_TICKS(4),
    .CNT_W       (3)
  ) u_dut (
    .mClk     (mClk),
    .Reset    (Reset),
    .Clk190   (Clk190),
    .btn_raw  (btn_raw),
    .tick     (tick),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_rel  (btn_rel)
  );

  initial mClk = 1'b0;
  always #5 mClk = ~mClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One mClk cycle; outputs sampled 1ns after the edge, Clk190 toggles every 4 cycles.
  task automatic cyc();
    @(posedge mClk);
    #1;
    if (run190) begin
      cnt190++;
      if (cnt190 == 4) begin
        Clk190 = ~Clk190;
        cnt190 = 0;
      end
    end
  endtask

  task automatic next_tick(input string tag);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!tick && k < 40);
    if (!tick) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic tick_chk(input string tag, input logic [3:0] lvl,
                          input logic [3:0] prs, input logic [3:0] rel);
    next_tick(tag);
    chk({tag, "_level"}, btn_level, lvl);
    chk({tag, "_press"}, btn_press, prs);
    chk({tag, "_rel"},   btn_rel,   rel);
  endtask

  initial begin
    bit saw;
    n_chk   = 0;
    n_pass  = 0;
    run190  = 1'b0;
    cnt190  = 0;
    Clk190  = 1'b1;
    Reset   = 1'b1;
    btn_raw = 4'b0000;

    // 1: reset with Clk190 high, no tick until a real 0->1
    repeat (3) cyc();
    chk("rst_tick",  tick,      0);
    chk("rst_level", btn_level, 0);
    chk("rst_press", btn_press, 0);
    chk("rst_rel",   btn_rel,   0);
    Reset = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      cyc();
      if (tick) saw = 1'b1;
    end
    chk("t1_no_tick_high", saw, 0);
    Clk190 = 1'b0;
    repeat (4) cyc();
    Clk190 = 1'b1;
    cyc();
    cyc();
    chk("t1_tick_early", tick, 0);
    cyc();
    chk("t1_tick_at3", tick, 1);
    cyc();
    chk("t1_tick_1cyc", tick, 0);
    chk("t1_level", btn_level, 0);
    cnt190 = 0;
    run190 = 1'b1;

    // 2: clean press on btn0
    btn_raw[0] = 1'b1;
    tick_chk("t2_k1", 4'b0000, 4'b0000, 4'b0000);
    tick_chk("t2_k2", 4'b0000, 4'b0000, 4'b0000);
    tick_chk("t2_k3", 4'b0000, 4'b0000, 4'b0000);
    tick_chk("t2_k4", 4'b0001, 4'b0001, 4'b0000);
    cyc();
    chk("t2_press_1cyc", btn_press, 0);
    chk("t2_level_hold", btn_level, 4'b0001);

    // 3: bouncing btn1 rejected, then qualifies
    btn_raw[1] = 1'b1;
    tick_chk("t3_b1", 4'b0001, 4'b0000, 4'b0000);
    btn_raw[1] = 1'b0;
    tick_chk("t3_b0", 4'b0001, 4'b0000, 4'b0000);
    btn_raw[1] = 1'b1;
    tick_chk("t3_b1b", 4'b0001, 4'b0000, 4'b0000);
    btn_raw[1] = 1'b0;
    tick_chk("t3_b0b", 4'b0001, 4'b0000, 4'b0000);
    btn_raw[1] = 1'b1;
    repeat (3) tick_chk("t3_q", 4'b0001, 4'b0000, 4'b0000);
    tick_chk("t3_q4", 4'b0011, 4'b0010, 4'b0000);

    // 4: btn2 press, aborted release, real release
    btn_raw[2] = 1'b1;
    repeat (3) tick_chk("t4_p", 4'b0011, 4'b0000, 4'b0000);
    tick_chk("t4_p4", 4'b0111, 4'b0100, 4'b0000);
    btn_raw[2] = 1'b0;
    tick_chk("t4_rp1", 4'b0111, 4'b0000, 4'b0000);
    btn_raw[2] = 1'b1;
    tick_chk("t4_back", 4'b0111, 4'b0000, 4'b0000);
    btn_raw[2] = 1'b0;
    repeat (3) tick_chk("t4_r", 4'b0111, 4'b0000, 4'b0000);
    tick_chk("t4_r4", 4'b0011, 4'b0000, 4'b0100);

    // 5: simultaneous press of btn0 and btn3 (btn0 released first)
    btn_raw[0] = 1'b0;
    repeat (3) tick_chk("t5_r", 4'b0011, 4'b0000, 4'b0000);
    tick_chk("t5_r4", 4'b0010, 4'b0000, 4'b0001);
    btn_raw[0] = 1'b1;
    btn_raw[3] = 1'b1;
    repeat (3) tick_chk("t5_p", 4'b0010, 4'b0000, 4'b0000);
    tick_chk("t5_p4", 4'b1011, 4'b1001, 4'b0000);

    // 6: reset while btn1 pending and btn2 pressed, then requalify
    btn_raw[1] = 1'b0;
    btn_raw[2] = 1'b1;
    repeat (3) tick_chk("t6_x", 4'b1011, 4'b0000, 4'b0000);
    tick_chk("t6_x4", 4'b1101, 4'b0100, 4'b0010);
    btn_raw[1] = 1'b1;
    tick_chk("t6_pp1", 4'b1101, 4'b0000, 4'b0000);
    tick_chk("t6_pp2", 4'b1101, 4'b0000, 4'b0000);
    cyc();
    Reset = 1'b1;
    cyc();
    chk("t6_rst_level", btn_level, 0);
    chk("t6_rst_press", btn_press, 0);
    chk("t6_rst_rel",   btn_rel,   0);
    chk("t6_rst_tick",  tick,      0);
    Reset = 1'b0;
    repeat (3) tick_chk("t6_rq", 4'b0000, 4'b0000, 4'b0000);
    tick_chk("t6_rq4", 4'b1111, 4'b1111, 4'b0000);
    cyc();
    chk("t6_press_1cyc", btn_press, 0);
    chk("t6_level_hold", btn_level, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
